// File: rtl/mmio_io_responder.sv
// Memory-mapped I/O responder: debounced switches, LED register, sticky
// switch rising-edge flags (write-1-to-clear) and status, with 1-cycle read data.
module mmio_io_responder #(
    parameter int unsigned BASE_ADDR       = 4096,
    parameter int unsigned DEBOUNCE_CYCLES = 65536,
    parameter int unsigned CNT_W           = 17
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    input  logic [15:0] SW,
    output logic [15:0] LED,
    output logic [31:0] io_rdata,
    output logic        io_hit_q,
    output logic        irq_edge
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [31:0]      offs;
    logic             hit;
    logic [1:0]       sel;
    logic             wr_led;
    logic             wr_edge;
    logic [15:0]      sw_meta;
    logic [15:0]      sw_sync;
    logic [15:0]      sw_stable;
    logic [15:0]      stable_nxt;
    logic [15:0]      rise;
    logic [15:0]      edge_flags;
    logic [15:0]      edge_nxt;
    logic [CNT_W-1:0] cnt     [16];
    logic [CNT_W-1:0] cnt_nxt [16];
    logic             sw_changing_any;
    logic [31:0]      rd_sel;
    logic             unused_data;

    // Offset subtraction makes the window check a simple upper-bits-zero test.
    assign offs    = address_dmem - BASE_ADDR;
    assign hit     = (offs[31:2] == 30'd0);
    assign sel     = offs[1:0];
    assign wr_led  = wren & hit & (sel == 2'd1);
    assign wr_edge = wren & hit & (sel == 2'd2);

    assign unused_data = ^data[31:16];

    always_comb begin
        stable_nxt      = sw_stable;
        sw_changing_any = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cnt_nxt[i]      = '0;
            sw_changing_any = sw_changing_any | (cnt[i] != '0);
            if (sw_sync[i] != sw_stable[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    stable_nxt[i] = sw_sync[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    // A rising edge arriving on the same cycle as a clear of that bit wins.
    assign rise     = stable_nxt & ~sw_stable;
    assign edge_nxt = (edge_flags & ~(wr_edge ? data[15:0] : 16'h0000)) | rise;

    always_comb begin
        rd_sel = '0;
        if (hit) begin
            case (sel)
                2'd0:    rd_sel = {16'h0000, sw_stable};
                2'd1:    rd_sel = {16'h0000, LED};
                2'd2:    rd_sel = {16'h0000, edge_flags};
                default: rd_sel = {30'd0, sw_changing_any, |edge_flags};
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sw_meta    <= '0;
            sw_sync    <= '0;
            sw_stable  <= '0;
            edge_flags <= '0;
            LED        <= '0;
            io_rdata   <= '0;
            io_hit_q   <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sw_meta    <= SW;
            sw_sync    <= sw_meta;
            sw_stable  <= stable_nxt;
            edge_flags <= edge_nxt;
            io_rdata   <= rd_sel;
            io_hit_q   <= hit;
            if (wr_led) begin
                LED <= data[15:0];
            end
            for (int i = 0; i < 16; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    assign irq_edge = |edge_flags;

endmodule

// File: tb/tb_mmio_io_responder.sv
// Self-checking bench for mmio_io_responder: directed scenarios plus a
// randomized phase, all compared against a run-length behavioural model.
module tb_mmio_io_responder;

    localparam int unsigned BASE = 4096;
    localparam int unsigned DEB  = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address_dmem = '0;
    logic [31:0] data = '0;
    logic        wren = 1'b0;
    logic [15:0] SW = '0;
    logic [15:0] LED;
    logic [31:0] io_rdata;
    logic        io_hit_q;
    logic        irq_edge;

    int n_checks = 0;
    int n_fail   = 0;

    mmio_io_responder #(
        .BASE_ADDR       (BASE),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (3)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .SW           (SW),
        .LED          (LED),
        .io_rdata     (io_rdata),
        .io_hit_q     (io_hit_q),
        .irq_edge     (irq_edge)
    );

    always #5 clock = ~clock;

    // Reference model: each switch bit accepts the synchronized value once it
    // has disagreed with the accepted value for DEB consecutive cycles.
    logic [15:0] m_s1, m_s2, m_stable, m_led, m_flags;
    logic [31:0] m_rdata;
    logic        m_hit;
    int          m_run [16];

    always @(posedge clock or negedge reset) begin
        logic [15:0] new_stable;
        logic        in_win;
        logic        changing;
        int          off;
        if (!reset) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_led = '0; m_flags = '0;
            m_rdata = '0; m_hit = 1'b0;
            for (int i = 0; i < 16; i++) m_run[i] = 0;
        end else begin
            in_win   = (address_dmem >= BASE) && (address_dmem <= BASE + 3);
            off      = int'(address_dmem - BASE);
            changing = 1'b0;
            for (int i = 0; i < 16; i++) if (m_run[i] != 0) changing = 1'b1;
            m_hit   = in_win;
            m_rdata = '0;
            if (in_win) begin
                case (off)
                    0: m_rdata = {16'h0, m_stable};
                    1: m_rdata = {16'h0, m_led};
                    2: m_rdata = {16'h0, m_flags};
                    default: m_rdata = {30'd0, changing, (m_flags != 0)};
                endcase
            end
            new_stable = m_stable;
            for (int i = 0; i < 16; i++) begin
                m_run[i] = (m_s2[i] != m_stable[i]) ? m_run[i] + 1 : 0;
                if (m_run[i] == DEB) begin
                    new_stable[i] = m_s2[i];
                    m_run[i] = 0;
                end
            end
            if (wren && in_win && off == 1) m_led = data[15:0];
            if (wren && in_win && off == 2) m_flags = m_flags & ~data[15:0];
            m_flags  = m_flags | (new_stable & ~m_stable);
            m_stable = new_stable;
            m_s2     = m_s1;
            m_s1     = SW;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One bus cycle: compare outputs against the model, then drive next inputs.
    task automatic step(input logic [31:0] a, input logic [31:0] d, input logic we, input logic [15:0] sw);
        @(negedge clock);
        check("rdata", io_rdata, m_rdata);
        check("hit_q", {31'd0, io_hit_q}, {31'd0, m_hit});
        check("led", {16'd0, LED}, {16'd0, m_led});
        check("irq", {31'd0, irq_edge}, {31'd0, (m_flags != 0)});
        address_dmem = a;
        data         = d;
        wren         = we;
        SW           = sw;
    endtask

    logic [15:0] sw_v;
    logic [15:0] led_save;
    logic [15:0] flags_save;
    logic        saw_changing;
    int          first_seen;

    initial begin
        #12 reset = 1'b1;

        // Reset asserted mid-cycle clears outputs without a clock edge.
        step(BASE + 1, 32'h0000_BEEF, 1'b1, 16'h0);
        step(BASE + 1, 32'h0, 1'b0, 16'h0);
        step(BASE + 5, 32'h0, 1'b0, 16'h0);
        check("pre_rst_led", {16'd0, LED}, 32'h0000_BEEF);
        check("pre_rst_hit", {31'd0, io_hit_q}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_led", {16'd0, LED}, 32'h0);
        check("rst_rdata", io_rdata, 32'h0);
        check("rst_hit", {31'd0, io_hit_q}, 32'h0);
        check("rst_irq", {31'd0, irq_edge}, 32'h0);
        step(BASE + 6, 32'h0, 1'b0, 16'h0);
        step(BASE + 6, 32'h0, 1'b0, 16'h0);
        #1 reset = 1'b1;

        // LED store then load.
        step(BASE + 1, 32'h1234_A5A5, 1'b1, 16'h0);
        step(BASE + 1, 32'h0, 1'b0, 16'h0);
        check("led_store", {16'd0, LED}, 32'h0000_A5A5);
        step(BASE + 6, 32'h0, 1'b0, 16'h0);
        check("led_load", io_rdata, 32'h0000_A5A5);
        check("led_load_hit", {31'd0, io_hit_q}, 32'd1);

        // SW[3] debounce latency.
        first_seen = -1;
        step(BASE, 32'h0, 1'b0, 16'h0008);
        for (int n = 1; n <= 12; n++) begin
            step(BASE, 32'h0, 1'b0, 16'h0008);
            if (first_seen < 0 && io_rdata[3]) first_seen = n;
        end
        check("sw3_latency", first_seen, 32'd7);
        step(BASE + 2, 32'h0, 1'b0, 16'h0008);
        step(BASE + 2, 32'h0, 1'b0, 16'h0008);
        check("sw3_flag", io_rdata, 32'h0000_0008);

        // 3-cycle glitch on SW[5] is rejected.
        for (int n = 0; n < 3; n++) step(BASE, 32'h0, 1'b0, 16'h0028);
        for (int n = 0; n < 10; n++) step(BASE, 32'h0, 1'b0, 16'h0008);
        check("glitch_stable", io_rdata, 32'h0000_0008);
        step(BASE + 2, 32'h0, 1'b0, 16'h0008);
        step(BASE + 2, 32'h0, 1'b0, 16'h0008);
        check("glitch_flags", io_rdata, 32'h0000_0008);

        // W1C, and set-wins on a coincident rise.
        for (int n = 0; n < 10; n++) step(BASE + 2, 32'h0, 1'b0, 16'h0009);
        check("flags_0009", io_rdata, 32'h0000_0009);
        step(BASE + 2, 32'h0000_0001, 1'b1, 16'h0009);
        step(BASE + 2, 32'h0, 1'b0, 16'h0009);
        step(BASE + 2, 32'h0, 1'b0, 16'h0009);
        check("w1c", io_rdata, 32'h0000_0008);
        for (int n = 0; n < 10; n++) step(BASE + 2, 32'h0, 1'b0, 16'h0008);
        check("fall_no_flag", io_rdata, 32'h0000_0008);
        step(BASE + 6, 32'h0, 1'b0, 16'h0009);
        for (int n = 1; n <= 4; n++) step(BASE + 6, 32'h0, 1'b0, 16'h0009);
        step(BASE + 2, 32'h0000_0001, 1'b1, 16'h0009);
        step(BASE + 2, 32'h0, 1'b0, 16'h0009);
        step(BASE + 2, 32'h0, 1'b0, 16'h0009);
        check("set_wins", io_rdata, 32'h0000_0009);

        // Writes to read-only and out-of-window addresses.
        led_save   = LED;
        flags_save = m_flags;
        step(BASE, 32'hFFFF_FFFF, 1'b1, 16'h0009);
        step(BASE + 3, 32'hFFFF_FFFF, 1'b1, 16'h0009);
        step(BASE + 4, 32'hFFFF_FFFF, 1'b1, 16'h0009);
        step(BASE + 4, 32'h0, 1'b0, 16'h0009);
        check("oow_hit", {31'd0, io_hit_q}, 32'd0);
        step(BASE + 2, 32'h0, 1'b0, 16'h0009);
        check("oow_rdata", io_rdata, 32'h0);
        check("ro_led", {16'd0, LED}, {16'd0, led_save});
        step(BASE + 2, 32'h0, 1'b0, 16'h0009);
        check("ro_flags", io_rdata, {16'd0, flags_save});

        // Bounce on SW[7], then settle high.
        saw_changing = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step(BASE + 3, 32'h0, 1'b0, ((c / 2) % 2 == 0) ? 16'h0089 : 16'h0009);
            saw_changing = saw_changing | io_rdata[1];
        end
        check("bounce_changing", {31'd0, saw_changing}, 32'd1);
        for (int n = 0; n < 12; n++) step(BASE + 3, 32'h0, 1'b0, 16'h0089);
        check("bounce_status", io_rdata, 32'h0000_0001);
        step(BASE + 2, 32'h0, 1'b0, 16'h0089);
        step(BASE + 2, 32'h0, 1'b0, 16'h0089);
        check("bounce_flags", io_rdata, 32'h0000_0089);

        // Randomized traffic against the model.
        sw_v = 16'h0089;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 7) == 0) sw_v[$urandom_range(0, 15)] ^= 1'b1;
            step(BASE + $urandom_range(0, 5) - 1, $urandom, ($urandom_range(0, 2) == 0), sw_v);
        end
        for (int n = 0; n < 12; n++) step(BASE + 3, 32'h0, 1'b0, sw_v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
